// File: rtl/mem_burst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_burst_ctrl
//  Description : Cache-to-main-memory transaction controller. A read request
//                becomes a BURST_LEN-beat line fill. A write request is a
//                single access that completes on one acknowledge. Memory
//                signals each beat/ack by changing the level of mem_stb.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Optional feature:
//    MEM_TIMEOUT_EN  - 8-bit watchdog. Aborts RBURST/WACK with an err pulse
//                      after 255 cycles without a beat. When undefined, err
//                      is tied low and the controller waits indefinitely.
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rst_n       clock, asynchronous active-low reset
//    req_valid/req_rd/req_addr  request from cache (rd=1 burst read)
//    req_ready        high only when idle; handshake = req_valid & req_ready
//    rsp_valid/rsp_data/rsp_last  one captured read beat per pulse
//    done             one-cycle pulse on normal completion
//    err              one-cycle pulse on watchdog abort
//    mem_rd/mem_addr/mem_act  request toward memory, held while mem_act
//    mem_rdata, mem_stb       memory read data and toggle strobe
// ============================================================================
module mem_burst_ctrl #(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_rd,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_act,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stb
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBURST = 2'd1,
        WACK   = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_stb_q;
    logic               r_stb_prev;
    logic               r_hist_ld;
    logic               r_hist_ok;
    logic [DATA_W-1:0]  r_rdata_q;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               w_beat;
    logic               w_last_beat;
    logic               w_timeout;

    // Strobe history. Read data is registered alongside the strobe so the
    // captured beat is the data that accompanied its toggle, even when the
    // memory toggles on consecutive cycles. r_hist_ok qualifies detection
    // only once r_stb_prev holds a real sample, so the first sample after
    // reset never counts as a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_q    <= 1'b0;
            r_stb_prev <= 1'b0;
            r_hist_ld  <= 1'b0;
            r_hist_ok  <= 1'b0;
            r_rdata_q  <= '0;
        end else begin
            r_stb_q    <= mem_stb;
            r_stb_prev <= r_stb_q;
            r_hist_ld  <= 1'b1;
            r_hist_ok  <= r_hist_ld;
            r_rdata_q  <= mem_rdata;
        end
    end

    assign w_beat      = r_hist_ok && (r_stb_q != r_stb_prev);
    assign w_last_beat = (r_beat_cnt == C_LAST_IDX);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_err;

    // Runs only while waiting on memory; any beat restarts it, and the
    // handshake restarts it because the count is held at zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= 8'd0;
        end else if ((r_state == RBURST) || (r_state == WACK)) begin
            if (w_beat) begin
                r_wdog <= 8'd0;
            end else if (!w_timeout) begin
                r_wdog <= r_wdog + 8'd1;
            end
        end else begin
            r_wdog <= 8'd0;
        end
    end

    assign w_timeout = (r_wdog == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= ((r_state == RBURST) || (r_state == WACK)) && !w_beat && w_timeout;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Main controller; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            done       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            mem_act    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        mem_addr   <= req_addr;
                        mem_rd     <= req_rd;
                        mem_act    <= 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= req_rd ? RBURST : WACK;
                    end else begin
                        // Entered from FIN/abort with req_ready low; raising
                        // it here makes it appear the cycle after done.
                        req_ready <= 1'b1;
                    end
                end
                RBURST: begin
                    if (w_beat) begin
                        rsp_valid  <= 1'b1;
                        rsp_data   <= r_rdata_q;
                        rsp_last   <= w_last_beat;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_state <= FIN;
                        end
                    end else if (w_timeout) begin
                        mem_act <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                WACK: begin
                    if (w_beat) begin
                        r_state <= FIN;
                    end else if (w_timeout) begin
                        mem_act <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    mem_act <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameter BURST_LEN, default 8: beats per read burst; legal range 2..16.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 64: beat data width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  cache requests a memory transaction.
REQ-007 req_rd  input  1  1 = burst read (line fill), 0 = single write.
REQ-008 req_addr  input  ADDR_W  transaction address.
REQ-009 req_ready  output  1  controller accepts a request this cycle.
REQ-010 rsp_valid  output  1  one read beat on rsp_data this cycle.
REQ-011 rsp_data  output  DATA_W  captured read beat.
REQ-012 rsp_last  output  1  qualifies the final read beat.
REQ-013 done  output  1  one-cycle pulse: transaction complete.
REQ-014 err  output  1  one-cycle pulse: transaction aborted by timeout.
REQ-015 mem_rd  output  1  read/write select to main memory (1 = read).
REQ-016 mem_addr  output  ADDR_W  address to main memory.
REQ-017 mem_act  output  1  transaction active toward memory.
REQ-018 mem_rdata  input  DATA_W  memory read data.
REQ-019 mem_stb  input  1  memory toggle strobe; each level change is one beat/ack.

Function
REQ-020 States: IDLE, RBURST, WACK, FIN; encoding is free.
REQ-021 req_ready = 1 only in IDLE; handshake when req_valid && req_ready.
REQ-022 On handshake, latch req_addr/req_rd into mem_addr/mem_rd and set mem_act = 1 the next cycle; go to RBURST if read, else WACK.
REQ-023 mem_stb is registered once; a beat is detected when the registered and previous-registered values differ.
REQ-024 RBURST: each detected toggle loads mem_rdata into rsp_data with rsp_valid = 1 for exactly one cycle, 1 cycle after detection.
REQ-025 Beat counter width is clog2(BURST_LEN), cleared on handshake and incremented per beat; rsp_last = 1 on beat index BURST_LEN-1.
REQ-026 After the last beat, go to FIN; further toggles in FIN/IDLE are ignored and raise no rsp_valid.
REQ-027 WACK: the first detected toggle completes the write and goes to FIN; no rsp_valid is raised.
REQ-028 FIN: done = 1 for one cycle, mem_act = 0, then IDLE; earliest next req_ready is the cycle after done.
REQ-029 mem_addr/mem_rd are held constant while mem_act = 1.
REQ-030 req_valid while busy is not accepted; the requester holds the request until req_ready.

Reset
REQ-031 rst_n low asynchronously forces IDLE; req_ready = 1, all other outputs 0, counters 0, stb history 0.
REQ-032 Reset mid-burst aborts silently, with no done/err; the first stb sample after reset only loads history and is never counted as a beat.

Configuration
REQ-033 Macro MEM_TIMEOUT_EN defined: an 8-bit watchdog clears on handshake and on every beat. If it reaches 255 in RBURST/WACK, err pulses for one cycle, done stays 0, mem_act drops, and the state returns to IDLE.
REQ-034 MEM_TIMEOUT_EN undefined: there is no watchdog, err is tied 0, and the controller waits indefinitely.

Verification
REQ-035 Read addr 0x100, 8 toggles 3 cycles apart -> 8 rsp_valid pulses with data matching mem_rdata, rsp_last on the 8th only, done once, then req_ready = 1.
REQ-036 Write addr 0x40, one toggle after 5 cycles -> mem_rd = 0, no rsp_valid, done 2 cycles after toggle detection.
REQ-037 New req_valid during a burst at beat 3 -> req_ready = 0 until after done; then accepted with the new mem_addr.
REQ-038 rst_n low after beat 4 -> outputs zero immediately; after release, a new read yields a full 8 beats counted from 0.
REQ-039 With MEM_TIMEOUT_EN, read with only 2 toggles -> err pulses 255 cycles after the last beat, no done, IDLE.
REQ-040 Back-to-back toggles on consecutive cycles -> every beat is captured and none is lost.
